// File: rtl/sifreleme_yurut_denetleyici.sv
// sifreleme_yurut_denetleyici: two-stage issue/retire wrapper around the combinational encryption unit.
// Define SIFRELEME_SAYAC_EN to add the retired-result and illegal-result counters.
`ifndef SIFRELEME_HMDST
`define SIFRELEME_HMDST 3'd0
`endif
`ifndef SIFRELEME_PKG
`define SIFRELEME_PKG 3'd1
`endif
`ifndef SIFRELEME_RVRS
`define SIFRELEME_RVRS 3'd2
`endif
`ifndef SIFRELEME_SLADD
`define SIFRELEME_SLADD 3'd3
`endif
`ifndef SIFRELEME_CNTZ
`define SIFRELEME_CNTZ 3'd4
`endif
`ifndef SIFRELEME_CNTP
`define SIFRELEME_CNTP 3'd5
`endif

module sifreleme_yurut_denetleyici #(
    parameter int RD_GEN   = 5,
    parameter int VERI_GEN = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                istek_gecerli_i,
    output logic                istek_hazir_o,
    input  logic [31:0]         buyruk_i,
    input  logic [VERI_GEN-1:0] rs1_deger_i,
    input  logic [VERI_GEN-1:0] rs2_deger_i,
    input  logic [RD_GEN-1:0]   rd_adres_i,
    input  logic                temizle_i,
    output logic [2:0]          kontrol_o,
    output logic [VERI_GEN-1:0] deger1_o,
    output logic [VERI_GEN-1:0] deger2_o,
    input  logic [VERI_GEN-1:0] sonuc_i,
    output logic                sonuc_gecerli_o,
    input  logic                sonuc_hazir_i,
    output logic [VERI_GEN-1:0] sonuc_o,
    output logic [RD_GEN-1:0]   sonuc_rd_o,
    output logic                gecersiz_o
`ifdef SIFRELEME_SAYAC_EN
    ,
    output logic [31:0]         tamamlanan_o,
    output logic [15:0]         gecersiz_sayisi_o
`endif
);
    logic [2:0]          f3, kod;
    logic                yasal, s2_bos, s1_ilerle, kabul;
    logic                s1_v_q, s1_v_d, s1_gec_q, s1_gec_d;
    logic [2:0]          s1_kon_q, s1_kon_d;
    logic [VERI_GEN-1:0] s1_d1_q, s1_d1_d, s1_d2_q, s1_d2_d;
    logic [RD_GEN-1:0]   s1_rd_q, s1_rd_d, s2_rd_q, s2_rd_d;
    logic                s2_v_q, s2_v_d, s2_gec_q, s2_gec_d;
    logic [VERI_GEN-1:0] s2_son_q, s2_son_d;
    logic                unused_buyruk;

    assign unused_buyruk = ^{buyruk_i[31:15], buyruk_i[11:7]};
    assign f3    = buyruk_i[14:12];
    assign yasal = buyruk_i[6:0] == 7'b0001011 && !(f3[2] && f3[1]);
    assign kod   = f3 == 3'b001 ? `SIFRELEME_PKG   :
                   f3 == 3'b010 ? `SIFRELEME_RVRS  :
                   f3 == 3'b011 ? `SIFRELEME_SLADD :
                   f3 == 3'b100 ? `SIFRELEME_CNTZ  :
                   f3 == 3'b101 ? `SIFRELEME_CNTP  : `SIFRELEME_HMDST;

    assign s2_bos        = !s2_v_q || sonuc_hazir_i;
    assign s1_ilerle     = s1_v_q && s2_bos;
    assign istek_hazir_o = !s1_v_q || s2_bos;
    assign kabul         = istek_gecerli_i && istek_hazir_o && !temizle_i;

    always_comb begin
        s1_v_d   = temizle_i ? 1'b0 : kabul ? 1'b1 : s1_ilerle ? 1'b0 : s1_v_q;
        s1_gec_d = kabul ? !yasal : s1_gec_q;
        s1_kon_d = kabul ? kod : s1_kon_q;
        s1_d1_d  = kabul ? rs1_deger_i : s1_d1_q;
        s1_d2_d  = kabul ? rs2_deger_i : s1_d2_q;
        s1_rd_d  = kabul ? rd_adres_i : s1_rd_q;
        s2_v_d   = temizle_i ? 1'b0 : s1_ilerle ? 1'b1 : s2_bos ? 1'b0 : s2_v_q;
        s2_son_d = (s1_ilerle && !temizle_i) ? (s1_gec_q ? '0 : sonuc_i) : s2_son_q;
        s2_gec_d = (s1_ilerle && !temizle_i) ? s1_gec_q : s2_gec_q;
        s2_rd_d  = (s1_ilerle && !temizle_i) ? s1_rd_q : s2_rd_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_v_q   <= 1'b0;
            s1_gec_q <= 1'b0;
            s1_kon_q <= `SIFRELEME_HMDST;
            s1_d1_q  <= '0;
            s1_d2_q  <= '0;
            s1_rd_q  <= '0;
            s2_v_q   <= 1'b0;
            s2_son_q <= '0;
            s2_gec_q <= 1'b0;
            s2_rd_q  <= '0;
        end else begin
            s1_v_q   <= s1_v_d;
            s1_gec_q <= s1_gec_d;
            s1_kon_q <= s1_kon_d;
            s1_d1_q  <= s1_d1_d;
            s1_d2_q  <= s1_d2_d;
            s1_rd_q  <= s1_rd_d;
            s2_v_q   <= s2_v_d;
            s2_son_q <= s2_son_d;
            s2_gec_q <= s2_gec_d;
            s2_rd_q  <= s2_rd_d;
        end
    end

    assign kontrol_o       = s1_kon_q;
    assign deger1_o        = s1_d1_q;
    assign deger2_o        = s1_d2_q;
    assign sonuc_gecerli_o = s2_v_q;
    assign sonuc_o         = s2_son_q;
    assign sonuc_rd_o      = s2_rd_q;
    assign gecersiz_o      = s2_gec_q;

`ifdef SIFRELEME_SAYAC_EN
    // Counts writeback handshakes; flush does not touch them.
    logic [31:0] tam_q, tam_d;
    logic [15:0] gsay_q, gsay_d;
    logic        teslim;

    assign teslim = s2_v_q && sonuc_hazir_i;

    always_comb begin
        tam_d  = teslim ? tam_q + 32'd1 : tam_q;
        gsay_d = (teslim && s2_gec_q) ? gsay_q + 16'd1 : gsay_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tam_q  <= '0;
            gsay_q <= '0;
        end else begin
            tam_q  <= tam_d;
            gsay_q <= gsay_d;
        end
    end

    assign tamamlanan_o      = tam_q;
    assign gecersiz_sayisi_o = gsay_q;
`endif
endmodule

// File: doc/sifreleme_yurut_denetleyici.md
Name: sifreleme_yurut_denetleyici

Overview:
- Two-stage issue/retire wrapper around the combinational encryption unit in the execute stage.
- Accepts a decoded X-extension instruction with its operands from the issue logic and decodes funct3 into the 3-bit `SIFRELEME_*` control code.
- Registers the control code and operands to drive the unit, captures the unit's result, and hands it to writeback over a valid/ready handshake with backpressure and flush.

Parameters:
- RD_GEN, 5, width of the destination register address.
- VERI_GEN, 32, operand and result width; only 32 is supported.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- istek_gecerli_i  input  1  issue request valid.
- istek_hazir_o  output  1  block can accept a request this cycle.
- buyruk_i  input  32  raw instruction word; only opcode [6:0] and funct3 [14:12] are used.
- rs1_deger_i  input  32  operand 1.
- rs2_deger_i  input  32  operand 2.
- rd_adres_i  input  RD_GEN  destination register address.
- temizle_i  input  1  pipeline flush.
- kontrol_o  output  3  drives the unit's kontrol_i.
- deger1_o  output  32  drives the unit's deger1_i.
- deger2_o  output  32  drives the unit's deger2_i.
- sonuc_i  input  32  the unit's sonuc_o, combinational from kontrol_o/deger*_o.
- sonuc_gecerli_o  output  1  result valid toward writeback.
- sonuc_hazir_i  input  1  writeback accepts the result.
- sonuc_o  output  32  result data.
- sonuc_rd_o  output  RD_GEN  destination address for the result.
- gecersiz_o  output  1  the returned instruction was illegal.

Behaviour:
- Decode: opcode must be 7'b0001011. funct3 maps to control codes:
  - 000 → `SIFRELEME_HMDST`
  - 001 → `SIFRELEME_PKG`
  - 010 → `SIFRELEME_RVRS`
  - 011 → `SIFRELEME_SLADD`
  - 100 → `SIFRELEME_CNTZ`
  - 101 → `SIFRELEME_CNTP`
  - 110, 111, or any other opcode → illegal.
- S1 (operand stage) registers: s1_v, kontrol, operands, rd, illegal flag. kontrol_o, deger1_o and deger2_o are driven directly from the S1 registers.
- S2 (result stage) registers: s2_v, result, rd, illegal flag. These drive sonuc_gecerli_o, sonuc_o, sonuc_rd_o and gecersiz_o.
- Handshake and advance rules:
  - s2_bos = !s2_v || sonuc_hazir_i
  - s1_ilerle = s1_v && s2_bos
  - istek_hazir_o = !s1_v || s2_bos (combinational)
  - Request accepted when istek_gecerli_i && istek_hazir_o.
- Latency and throughput:
  - Accept at edge N → S1 valid after N.
  - Result in S2 after edge N+1; sonuc_gecerli_o high during cycle N+2 at the earliest.
  - Throughput is one instruction per cycle when sonuc_hazir_i is held high.
- Capture into S2 on s1_ilerle:
  - legal instruction: result ← sonuc_i.
  - illegal instruction: result ← 32'h0 and illegal flag ← 1.
- Stall: while sonuc_gecerli_o && !sonuc_hazir_i, S2 holds all outputs stable and S1 holds. kontrol_o, deger1_o and deger2_o do not change.
- Idle: when S1 is empty, kontrol_o, deger1_o and deger2_o hold their last values. They are not zeroed.
- Simultaneous events: if S1 moves to S2 and a new request is accepted in the same cycle, both happen.
- Flush: temizle_i clears s1_v and s2_v at the next edge. Any request presented in the flush cycle is dropped. Flush has priority over accept and advance.
- Reset (including mid-operation): clears s1_v, s2_v and all data registers. Outputs after reset:
  - sonuc_gecerli_o = 0, sonuc_o = 0, sonuc_rd_o = 0, gecersiz_o = 0
  - kontrol_o = `SIFRELEME_HMDST`, deger1_o = 0, deger2_o = 0
  - istek_hazir_o = 1 (combinational).

Optional Feature:
- Macro SIFRELEME_SAYAC_EN.
- Defined:
  - Output tamamlanan_o [31:0] counts results accepted by writeback (sonuc_gecerli_o && sonuc_hazir_i), legal or illegal.
  - Output gecersiz_sayisi_o [15:0] counts accepted illegal results.
  - Both counters wrap modulo their width, are not affected by temizle_i, and are cleared by rst_i.
- Undefined: neither port nor any counter logic exists.

Test Plan:
- Reset, then a CNTP request with funct3=101, rs1=32'hF0F0_0001, rd=5, sonuc_hazir_i=1 → two cycles later: sonuc_gecerli_o=1, sonuc_o=9, sonuc_rd_o=5, gecersiz_o=0.
- Back-to-back HMDST(rs1=32'hFFFF_FFFF, rs2=0), then CNTZ(rs1=32'h0000_00FF) → results 32 and 24 on consecutive cycles; istek_hazir_o stays 1.
- Hold sonuc_hazir_i=0 with both stages full → istek_hazir_o=0 and outputs stable for 5 cycles; release → results drain in order, one per cycle.
- funct3=111, rd=3 → sonuc_o=0, gecersiz_o=1, sonuc_rd_o=3.
- Assert temizle_i with S1 and S2 full and a new request pending → next cycle sonuc_gecerli_o=0 and nothing retires; the next request after flush completes normally.
- SIFRELEME_SAYAC_EN: retire 3 legal and 1 illegal instruction, then flush one in flight → tamamlanan_o=4, gecersiz_sayisi_o=1; rst_i → both 0.
